// File: rtl/cgra_cfg_pkg.sv
// Shared definitions for the CGRA configuration loader: FSM encoding and
// counter sizing helpers.
package cgra_cfg_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLR,
      ST_LOAD,
      ST_SHIFT,
      ST_DONE
   } ldr_state_e;

   localparam int CFG_PHASE_W = 1;

   // Width needed to count from 0 up to and including n.
   function automatic int cfg_cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/cfg_word_serializer.sv
// Word-wide shift register that hands out one bit at a time, LSB first,
// and flags when every bit of the held word has been consumed.
module cfg_word_serializer
   import cgra_cfg_pkg::*;
#(
   parameter int WORD_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              load,
   input  logic              shift,
   input  logic [WORD_W-1:0] word_i,
   output logic              bit_o,
   output logic              empty_o
);

   localparam int CW = cfg_cnt_w(WORD_W);

   logic [WORD_W-1:0] sr_q, sr_d;
   logic [CW-1:0]     cnt_q, cnt_d;

   always_comb begin
      sr_d  = sr_q;
      cnt_d = cnt_q;
      if (flush) begin
         cnt_d = '0;
      end else if (load) begin
         sr_d  = word_i;
         cnt_d = CW'(WORD_W);
      end else if (shift) begin
         sr_d  = {1'b0, sr_q[WORD_W-1:1]};
         cnt_d = cnt_q - CW'(1);
      end
   end

   // Only the bit counter needs a reset; stale word data is never observed
   // because an empty counter gates every use of it.
   always_ff @(posedge clk) begin
      sr_q <= sr_d;
      if (!reset) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign bit_o   = sr_q[0];
   assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/pe_config_loader.sv
// Feeds a PE configuration scan chain: clears it, then shifts CHAIN_LEN bits
// from a valid/ready word stream while watching the chain tail for corruption.
module pe_config_loader
   import cgra_cfg_pkg::*;
#(
   parameter int WORD_W    = 32,
   parameter int CHAIN_LEN = 64,
   parameter int CLR_CYC   = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [WORD_W-1:0] s_data,
   input  logic              s_valid,
   output logic              s_ready,
   output logic              config_clk,
   output logic              config_reset,
   output logic              config_in,
   input  logic              config_out,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int CNT_W = cfg_cnt_w(CHAIN_LEN);
   localparam int CLR_W = cfg_cnt_w(CLR_CYC);

   ldr_state_e             state_q, state_d;
   logic [CFG_PHASE_W-1:0] phase_q, phase_d;
   logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
   logic [CLR_W-1:0]       clr_cnt_q, clr_cnt_d;
   logic config_clk_q, config_clk_d, config_reset_q, config_reset_d;
   logic config_in_q, config_in_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic ser_load, ser_shift, ser_flush, ser_bit, ser_empty;

   cfg_word_serializer #(.WORD_W(WORD_W)) u_ser (
      .clk     (clk),
      .reset   (reset),
      .flush   (ser_flush),
      .load    (ser_load),
      .shift   (ser_shift),
      .word_i  (s_data),
      .bit_o   (ser_bit),
      .empty_o (ser_empty)
   );

   assign s_ready = (state_q == ST_LOAD) && ser_empty;

   always_comb begin
      state_d        = state_q;
      phase_d        = phase_q;
      bit_cnt_d      = bit_cnt_q;
      clr_cnt_d      = clr_cnt_q;
      config_clk_d   = config_clk_q;
      config_reset_d = config_reset_q;
      config_in_d    = config_in_q;
      busy_d         = busy_q;
      done_d         = 1'b0;
      err_d          = err_q;
      ser_load       = 1'b0;
      ser_shift      = 1'b0;
      ser_flush      = 1'b0;
      unique case (state_q)
         ST_IDLE: if (start) begin
            state_d        = ST_CLR;
            clr_cnt_d      = '0;
            bit_cnt_d      = '0;
            phase_d        = '0;
            config_reset_d = 1'b1;
            busy_d         = 1'b1;
            err_d          = 1'b0;
            ser_flush      = 1'b1;
         end
         ST_CLR: begin
            if (clr_cnt_q == CLR_W'(CLR_CYC - 1)) begin
               state_d        = ST_LOAD;
               config_reset_d = 1'b0;
            end else begin
               clr_cnt_d = clr_cnt_q + CLR_W'(1);
            end
         end
         ST_LOAD: if (s_valid && s_ready) begin
            // The first bit goes out with the shift state itself, so present it now.
            ser_load    = 1'b1;
            state_d     = ST_SHIFT;
            phase_d     = '0;
            config_in_d = s_data[0];
         end
         ST_SHIFT: begin
            if (phase_q == '0) begin
               config_clk_d = 1'b1;
               phase_d      = 1'b1;
               ser_shift    = 1'b1;
               if (config_out) err_d = 1'b1;
            end else begin
               config_clk_d = 1'b0;
               phase_d      = '0;
               bit_cnt_d    = bit_cnt_q + CNT_W'(1);
               if (bit_cnt_q == CNT_W'(CHAIN_LEN - 1)) begin
                  state_d     = ST_DONE;
                  done_d      = 1'b1;
                  config_in_d = 1'b0;
               end else if (ser_empty) begin
                  state_d = ST_LOAD;
               end else begin
                  config_in_d = ser_bit;
               end
            end
         end
         ST_DONE: begin
            state_d   = ST_IDLE;
            busy_d    = 1'b0;
            ser_flush = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q        <= ST_IDLE;
         phase_q        <= '0;
         bit_cnt_q      <= '0;
         clr_cnt_q      <= '0;
         config_clk_q   <= 1'b0;
         config_reset_q <= 1'b0;
         config_in_q    <= 1'b0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         err_q          <= 1'b0;
      end else begin
         state_q        <= state_d;
         phase_q        <= phase_d;
         bit_cnt_q      <= bit_cnt_d;
         clr_cnt_q      <= clr_cnt_d;
         config_clk_q   <= config_clk_d;
         config_reset_q <= config_reset_d;
         config_in_q    <= config_in_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
         err_q          <= err_d;
      end
   end

   assign config_clk   = config_clk_q;
   assign config_reset = config_reset_q;
   assign config_in    = config_in_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign err          = err_q;

endmodule

// File: tb/tb_pe_config_loader.sv
// Scoreboard bench for pe_config_loader with a 40-bit behavioural chain model.
module tb_pe_config_loader;

   localparam int WORD_W    = 32;
   localparam int CHAIN_LEN = 40;
   localparam int CLR_CYC   = 2;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              start = 1'b0;
   logic [WORD_W-1:0] s_data = '0;
   logic              s_valid = 1'b0;
   logic              s_ready, config_clk, config_reset, config_in, config_out;
   logic              busy, done, err;

   pe_config_loader #(.WORD_W(WORD_W), .CHAIN_LEN(CHAIN_LEN), .CLR_CYC(CLR_CYC)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .s_data       (s_data),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .config_clk   (config_clk),
      .config_reset (config_reset),
      .config_in    (config_in),
      .config_out   (config_out),
      .busy         (busy),
      .done         (done),
      .err          (err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural chain: head receives config_in, tail drives config_out.
   logic [CHAIN_LEN-1:0] chain = '0;
   bit                   stuck = 1'b0;
   int                   cfg_edges = 0;
   always @(posedge config_clk or posedge config_reset)
      if (config_reset) chain <= '0;
      else              chain <= {config_in, chain[CHAIN_LEN-1:1]};
   always @(posedge config_clk) cfg_edges <= cfg_edges + 1;
   assign config_out = stuck ? 1'b1 : chain[0];

   typedef struct {
      int                   start_cyc;
      int                   start_edges;
      logic [CHAIN_LEN-1:0] exp_chain;
      logic                 exp_err;
      int                   exp_lat;
   } exp_t;
   exp_t sb[$];

   int checks = 0;
   int errors = 0;
   int bad_rdy = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: compares every completed load against the queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (s_ready && (config_clk || config_reset || !busy || done)) bad_rdy++;
         if (done === 1'b1) begin
            if (sb.size() == 0) begin
               check("unexpected_done", 1, 0);
            end else begin
               e = sb.pop_front();
               check("done_latency", cyc - e.start_cyc, e.exp_lat);
               check("chain_contents", chain, e.exp_chain);
               check("err_at_done", err, e.exp_err);
               check("cfg_clk_edges", cfg_edges - e.start_edges, CHAIN_LEN);
               check("cfg_clk_low_at_done", config_clk, 0);
               check("cfg_in_low_at_done", config_in, 0);
            end
         end
      end
   end

   task automatic pulse_start(output int sc, output int se);
      @(posedge clk); #1;
      start = 1'b1;
      sc = cyc;
      se = cfg_edges;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic send_word(input logic [WORD_W-1:0] w);
      bit ok = 1'b0;
      s_data  = w;
      s_valid = 1'b1;
      for (int i = 0; i < 300 && !ok; i++) begin
         @(negedge clk);
         if (s_ready) begin
            @(posedge clk); #1;
            ok = 1'b1;
         end
      end
      s_valid = 1'b0;
      if (!ok) check("handshake_timeout", 0, 1);
   endtask

   task automatic wait_done();
      bit seen = 1'b0;
      for (int i = 0; i < 400 && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      if (!seen) check("done_timeout", 0, 1);
      @(posedge clk); #1;
   endtask

   task automatic run_load(input logic [WORD_W-1:0] w0, input logic [WORD_W-1:0] w1,
                           input int gap, input logic [CHAIN_LEN-1:0] exp_chain,
                           input bit exp_err, input int lat, input bit busy_start);
      int   sc, se;
      exp_t e;
      bit   seen = 1'b0;
      pulse_start(sc, se);
      e.start_cyc = sc; e.start_edges = se; e.exp_chain = exp_chain;
      e.exp_err = exp_err; e.exp_lat = lat;
      sb.push_back(e);
      check("busy_after_start", busy, 1);
      check("err_cleared_by_start", err, 0);
      check("cfg_reset_in_clr", config_reset, 1);
      send_word(w0);
      @(posedge clk); #1;
      check("err_after_bit0", err, exp_err);
      if (busy_start) begin
         start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
      end
      if (gap > 0) begin
         for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (s_ready) seen = 1'b1;
         end
         if (!seen) check("gap_ready_timeout", 0, 1);
         for (int i = 0; i < gap; i++) begin
            @(posedge clk); #1;
            check("gap_cfg_clk_low", config_clk, 0);
            check("gap_cfg_in_hold", config_in, w0[WORD_W-1]);
         end
      end
      send_word(w1);
      wait_done();
   endtask

   initial begin
      int sc, se, rdy_seen;
      // Reset state, with a start that must be swallowed by reset.
      repeat (3) @(posedge clk);
      #1 start = 1'b1;
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_s_ready", s_ready, 0);
      check("rst_cfg_clk", config_clk, 0);
      check("rst_cfg_reset", config_reset, 0);
      check("rst_cfg_in", config_in, 0);
      @(posedge clk); #1;
      reset = 1'b1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1 check("start_during_reset_ignored", busy, 0);

      // Basic two-word load.
      run_load(32'hDEADBEEF, 32'h000000A5, 0, 40'hA5_DEADBEEF, 1'b0, 85, 1'b0);
      // Source stalls 10 cycles before word 2.
      run_load(32'hDEADBEEF, 32'h000000A5, 10, 40'hA5_DEADBEEF, 1'b0, 95, 1'b0);
      // Tail stuck at 1.
      stuck = 1'b1;
      run_load(32'hDEADBEEF, 32'h000000A5, 0, 40'hA5_DEADBEEF, 1'b1, 85, 1'b0);
      check("err_sticky_after_done", err, 1);
      stuck = 1'b0;

      // Reset during bit 20 aborts the load.
      pulse_start(sc, se);
      send_word(32'h0F0F0F0F);
      while (cyc < sc + 44) begin
         @(posedge clk); #1;
      end
      reset = 1'b0;
      @(posedge clk); #1;
      check("abort_busy", busy, 0);
      check("abort_cfg_clk", config_clk, 0);
      check("abort_cfg_reset", config_reset, 0);
      check("abort_s_ready", s_ready, 0);
      check("abort_done", done, 0);
      reset = 1'b1;
      run_load(32'hDEADBEEF, 32'h000000A5, 0, 40'hA5_DEADBEEF, 1'b0, 85, 1'b0);

      // Start while busy, then a word offered after done.
      run_load(32'hCAFEF00D, 32'h0000005A, 0, 40'h5A_CAFEF00D, 1'b0, 85, 1'b1);
      s_data   = 32'h11223344;
      s_valid  = 1'b1;
      rdy_seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (s_ready) rdy_seen++;
      end
      s_valid = 1'b0;
      check("word_after_done_refused", rdy_seen, 0);
      check("idle_after_extra_word", busy, 0);

      // Upper bits of the final word are discarded.
      run_load(32'h12345678, 32'hFFFFFF00, 0, 40'h00_12345678, 1'b0, 85, 1'b0);

      repeat (5) @(posedge clk);
      check("s_ready_only_in_load", bad_rdy, 0);
      check("scoreboard_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
